// File: rtl/sd_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
package sd_pkg;

    localparam logic [3:0] SD_PAT_1011 = 4'b1011;

    function automatic int sd_state_w(input int len);
        return $clog2(len + 1);
    endfunction

    // Bit idx of the pattern in arrival order (idx 0 is the first bit received).
    function automatic logic sd_pat_bit(input logic [15:0] pattern, input int len, input int idx);
        logic [15:0] sh;
        sh = pattern >> (len - 1 - idx);
        return sh[0];
    endfunction

    // Longest pattern prefix that is a proper suffix of (first `state` pattern bits, then b).
    function automatic int sd_fail(input logic [15:0] pattern, input int len,
                                   input int state, input logic b);
        int best;
        best = 0;
        for (int k = state; k >= 1; k--) begin
            logic ok;
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                int   t;
                logic tb;
                t  = state + 1 - k + j;
                tb = (t == state) ? b : sd_pat_bit(pattern, len, t);
                if (tb != sd_pat_bit(pattern, len, j)) ok = 1'b0;
            end
            if (ok && best == 0) best = k;
        end
        return best;
    endfunction

endpackage

// File: rtl/sd_match_counter.sv
// Saturating event counter used for the optional match count (SD_MATCH_COUNT_EN).
module sd_match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sequence_detector.sv
// Moore serial pattern detector with KMP-style fallback; define SD_MATCH_COUNT_EN
// to add a saturating match_count output.
module sequence_detector
    import sd_pkg::*;
#(
    parameter int             LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = SD_PAT_1011,
    parameter bit             OVERLAP = 1'b1
`ifdef SD_MATCH_COUNT_EN
    ,
    parameter int             CNT_W   = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    output logic             o
`ifdef SD_MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    localparam int STATE_W = sd_state_w(LEN);

    localparam logic [STATE_W-1:0] RESTART =
        OVERLAP ? STATE_W'(sd_fail(16'(PATTERN), LEN, LEN - 1, PATTERN[0])) : '0;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic               hit;
    logic [STATE_W-1:0] fail0 [LEN];
    logic [STATE_W-1:0] fail1 [LEN];
    logic [LEN-1:0]     exp_bits;

    // Fallback targets are fixed by the pattern, so they become constants here.
    for (genvar s = 0; s < LEN; s++) begin : g_tab
        localparam int F0 = sd_fail(16'(PATTERN), LEN, s, 1'b0);
        localparam int F1 = sd_fail(16'(PATTERN), LEN, s, 1'b1);
        assign fail0[s]    = STATE_W'(F0);
        assign fail1[s]    = STATE_W'(F1);
        assign exp_bits[s] = PATTERN[LEN-1-s];
    end

    always_comb begin
        state_nxt = '0;
        hit       = 1'b0;
        for (int s = 0; s < LEN; s++) begin
            if (state == STATE_W'(s)) begin
                if (i == exp_bits[s]) begin
                    if (s == LEN - 1) begin
                        hit       = 1'b1;
                        state_nxt = RESTART;
                    end else begin
                        state_nxt = STATE_W'(s + 1);
                    end
                end else begin
                    state_nxt = i ? fail1[s] : fail0[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            o     <= 1'b0;
        end else begin
            state <= state_nxt;
            o     <= hit;
        end
    end

`ifdef SD_MATCH_COUNT_EN
    sd_match_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit && !rst),
        .count(match_count)
    );
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Scoreboard bench: three detector configurations share one serial stream and are
// checked against a sliding-window reference model.
module tb_sequence_detector;

    logic clk_tb;
    logic rst;
    logic i;
    logic o_a;
    logic o_b;
    logic o_c;

    int cmp_count;
    int err_count;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       c;
        logic [1:0] cnt;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] hist_a, hist_b, hist_c;
    int          len_a, len_b, len_c;
    logic [1:0]  cnt_model;

`ifdef SD_MATCH_COUNT_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [1:0] cnt_c;
`endif

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    sequence_detector #(
        .LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)
    ) dut_a (
        .clk(clk_tb), .rst(rst), .i(i), .o(o_a)
`ifdef SD_MATCH_COUNT_EN
        , .match_count(cnt_a)
`endif
    );

    sequence_detector #(
        .LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)
    ) dut_b (
        .clk(clk_tb), .rst(rst), .i(i), .o(o_b)
`ifdef SD_MATCH_COUNT_EN
        , .match_count(cnt_b)
`endif
    );

    sequence_detector #(
        .LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1)
`ifdef SD_MATCH_COUNT_EN
        , .CNT_W(2)
`endif
    ) dut_c (
        .clk(clk_tb), .rst(rst), .i(i), .o(o_c)
`ifdef SD_MATCH_COUNT_EN
        , .match_count(cnt_c)
`endif
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        cmp_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic clearModel();
        hist_a    = '0; hist_b = '0; hist_c = '0;
        len_a     = 0;  len_b  = 0;  len_c  = 0;
        cnt_model = '0;
    endtask

    // Pop the oldest expectation and compare it against what the DUTs show now.
    task automatic compareOutputs(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 8'd1, 8'd0);
            return;
        end
        e = sbq.pop_front();
        checkOutput({tag, "_a"}, {7'd0, o_a}, {7'd0, e.a});
        checkOutput({tag, "_b"}, {7'd0, o_b}, {7'd0, e.b});
        checkOutput({tag, "_c"}, {7'd0, o_c}, {7'd0, e.c});
`ifdef SD_MATCH_COUNT_EN
        checkOutput({tag, "_cnt"}, {6'd0, cnt_c}, {6'd0, e.cnt});
`endif
    endtask

    task automatic applyStimulus(input logic b, input string tag);
        exp_t e;
        rst = 1'b0;
        i   = b;
        hist_a = {hist_a[14:0], b}; if (len_a < 16) len_a++;
        hist_b = {hist_b[14:0], b}; if (len_b < 16) len_b++;
        hist_c = {hist_c[14:0], b}; if (len_c < 16) len_c++;
        e.a = (len_a >= 4) && (hist_a[3:0] == 4'b1011);
        e.b = (len_b >= 4) && (hist_b[3:0] == 4'b1011);
        e.c = (len_c >= 4) && (hist_c[3:0] == 4'b1111);
        if (e.b) len_b = 0;
        if (e.c && cnt_model != 2'd3) cnt_model++;
        e.cnt = cnt_model;
        sbq.push_back(e);
        @(posedge clk_tb);
        @(negedge clk_tb);
        compareOutputs(tag);
    endtask

    task automatic applyReset(input logic b, input string tag);
        exp_t e;
        rst = 1'b1;
        i   = b;
        clearModel();
        e = '0;
        sbq.push_back(e);
        @(posedge clk_tb);
        @(negedge clk_tb);
        compareOutputs(tag);
    endtask

    task automatic applyStream(input logic [15:0] bits, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            applyStimulus(bits[k], $sformatf("%s_%0d", tag, k + 1));
        end
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        rst = 1'b1;
        i   = 1'b0;
        clearModel();
        @(negedge clk_tb);

        applyReset(1'b0, "reset0");
        applyReset(1'b1, "reset1");

        // LSB-first 10'b0001101011: single pulse after the 7th bit
        applyStream(16'b0000_0000_1101_0110 >> 1 | 16'b0, 0, "none");
        applyStream({6'd0, 10'b0001101011}, 10, "stream10");

        applyReset(1'b0, "rst_a");
        applyStream({9'd0, 7'b1101101}, 7, "overlap");

        applyReset(1'b0, "rst_b");
        applyStream({13'd0, 3'b101}, 3, "partial");
        applyReset(1'b1, "midrst");
        applyStimulus(1'b1, "after_rst");

        applyReset(1'b0, "rst_c");
        applyStream(16'h00ff, 8, "ones");

        applyReset(1'b1, "held1");
        applyReset(1'b0, "held2");
        applyReset(1'b1, "held3");
        applyReset(1'b1, "held4");

        for (int k = 0; k < 48; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), $sformatf("rand_%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
